row_window_buffer: RTL and testbench



---
 rtl/row_window_buffer.sv | 100 ++++++++++
 tb/tb_row_window_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/row_window_buffer.sv
// Circular row buffer that presents the oldest KROWS rows as one rotated window.
// Optional accepted-window counter output win_cnt is built when ROWBUF_WINCNT_EN is defined.
module row_window_buffer #(
    parameter int DW     = 64,
    parameter int ROWS   = 4,
    parameter int KROWS  = 3,
    parameter int STRIDE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DW-1:0]               in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [KROWS*DW-1:0]         out_data,
`ifdef ROWBUF_WINCNT_EN
    output logic [15:0]                 win_cnt,
`endif
    output logic [$clog2(ROWS+1)-1:0]   count
);

    localparam int CW = $clog2(ROWS + 1);
    localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [DW-1:0] mem [ROWS];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          push;
    logic          pop;

    // Modulo-ROWS increment; inc is always below 2*ROWS so one subtraction suffices.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned inc);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(inc);
        if (s >= (PW+1)'(ROWS)) begin
            s = s - (PW+1)'(ROWS);
        end
        return s[PW-1:0];
    endfunction

    assign in_ready  = (count < CW'(ROWS));
    assign out_valid = (count >= CW'(KROWS));
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(STRIDE);
            2'b11:   count_nxt = count + CW'(1) - CW'(STRIDE);
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < KROWS; i++) begin
            out_data[i*DW +: DW] = mem[ptr_add(rd_ptr, i)];
        end
    end

    // Row storage carries no reset; stale contents are never exposed while out_valid=0.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_add(wr_ptr, 1);
            end
            if (pop) begin
                rd_ptr <= ptr_add(rd_ptr, STRIDE);
            end
            count <= count_nxt;
        end
    end

`ifdef ROWBUF_WINCNT_EN
    // Survives flush so frame boundaries do not lose the running window total.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt <= '0;
        end else if (pop && !flush) begin
            win_cnt <= win_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_row_window_buffer.sv
// Directed self-checking bench for row_window_buffer (default build and a ROWS=5/STRIDE=2 instance).
module tb_row_window_buffer;

    logic          clk = 1'b0;
    logic          rst, flush;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [63:0]   in_data;
    logic [191:0]  out_data;
    logic [2:0]    count;
    logic          in_valid5, in_ready5, out_valid5, out_ready5;
    logic [63:0]   in_data5;
    logic [191:0]  out_data5;
    logic [2:0]    count5;
`ifdef ROWBUF_WINCNT_EN
    logic [15:0]   win_cnt, win_cnt5;
`endif

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    row_window_buffer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef ROWBUF_WINCNT_EN
        .win_cnt(win_cnt),
`endif
        .count(count)
    );

    row_window_buffer #(.DW(64), .ROWS(5), .KROWS(3), .STRIDE(2)) dut5 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_data(in_data5),
        .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
`ifdef ROWBUF_WINCNT_EN
        .win_cnt(win_cnt5),
`endif
        .count(count5)
    );

    function automatic logic [63:0] rowv(input int i);
        return {32'hDA7A_0000 | 32'(i), ~32'(i)};
    endfunction

    function automatic logic [191:0] win(input int a, input int b, input int c);
        return {rowv(c), rowv(b), rowv(a)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int nxt, k, maxc;
`ifdef ROWBUF_WINCNT_EN
        logic [15:0] wc_before;
`endif
        rst = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid5 = 1'b0; in_data5 = '0; out_ready5 = 1'b0;
        tick; tick;
        chk("rst_count", 192'(count), 192'(0));
        chk("rst_in_ready", 192'(in_ready), 192'(1));
        chk("rst_out_valid", 192'(out_valid), 192'(0));
        chk("rst5_count", 192'(count5), 192'(0));
`ifdef ROWBUF_WINCNT_EN
        chk("rst_win_cnt", 192'(win_cnt), 192'(0));
`endif
        rst = 1'b0;

        // A,B,C,D with out_ready held high
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = rowv(1); tick;
        chk("fill1_count", 192'(count), 192'(1));
        chk("fill1_out_valid", 192'(out_valid), 192'(0));
        in_data = rowv(2); tick;
        chk("fill2_out_valid", 192'(out_valid), 192'(0));
        in_data = rowv(3); tick;
        chk("fill3_count", 192'(count), 192'(3));
        chk("fill3_out_valid", 192'(out_valid), 192'(1));
        chk("win_CBA", out_data, win(1, 2, 3));
        in_data = rowv(4); tick;
        chk("pushpop_count", 192'(count), 192'(3));
        chk("win_DCB", out_data, win(2, 3, 4));
        in_valid = 1'b0; tick;
        chk("drain_count", 192'(count), 192'(2));
        chk("drain_out_valid", 192'(out_valid), 192'(0));

        // Fill to full with out_ready low
        flush = 1'b1; tick; flush = 1'b0;
        chk("flush_count", 192'(count), 192'(0));
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = rowv(10 + i); tick;
        end
        chk("full_count", 192'(count), 192'(4));
        chk("full_in_ready", 192'(in_ready), 192'(0));
        in_data = rowv(14); tick;
        chk("reject_count", 192'(count), 192'(4));
        chk("stall_win", out_data, win(10, 11, 12));
        out_ready = 1'b1; tick;
        chk("fullpop_count", 192'(count), 192'(3));
        chk("fullpop_in_ready", 192'(in_ready), 192'(1));
        chk("fullpop_win", out_data, win(11, 12, 13));
        out_ready = 1'b0; in_data = rowv(15); tick;
        chk("refill_count", 192'(count), 192'(4));
        in_valid = 1'b0; out_ready = 1'b1; tick;
        chk("row14_dropped_win", out_data, win(12, 13, 15));
        chk("row14_dropped_count", 192'(count), 192'(3));

        // Flush with count=3, a push and a pop pending
`ifdef ROWBUF_WINCNT_EN
        wc_before = win_cnt;
        chk("wc_before_flush", 192'(wc_before), 192'(4));
`endif
        flush = 1'b1; in_valid = 1'b1; in_data = rowv(16); out_ready = 1'b1; tick;
        chk("flush3_count", 192'(count), 192'(0));
        chk("flush3_out_valid", 192'(out_valid), 192'(0));
        chk("flush3_in_ready", 192'(in_ready), 192'(1));
`ifdef ROWBUF_WINCNT_EN
        chk("flush3_win_cnt", 192'(win_cnt), 192'(wc_before));
`endif
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; tick;
        chk("flush3_discard", 192'(count), 192'(0));

        // Ten rows with continuous pop, across several pointer wraps
        out_ready = 1'b1; nxt = 0; k = 0;
        for (int c = 0; c < 14; c++) begin
            in_valid = (nxt < 10);
            in_data  = rowv(100 + nxt);
            if (out_valid) begin
                chk($sformatf("wrap_win%0d", k), out_data, win(100 + k, 101 + k, 102 + k));
                k++;
            end
            tick;
            if (nxt < 10) nxt++;
        end
        in_valid = 1'b0;
        chk("wrap_windows", 192'(k), 192'(8));
        chk("wrap_count", 192'(count), 192'(2));
`ifdef ROWBUF_WINCNT_EN
        chk("wrap_win_cnt", 192'(win_cnt), 192'(12));
`endif

        // ROWS=5, STRIDE=2 instance
        out_ready5 = 1'b1; nxt = 0; k = 0; maxc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid5 = (nxt < 7);
            in_data5  = rowv(200 + nxt);
            if (out_valid5) begin
                chk($sformatf("s2_win%0d", k), out_data5, win(200 + 2*k, 201 + 2*k, 202 + 2*k));
                k++;
            end
            tick;
            if (int'(count5) > maxc) maxc = int'(count5);
            if (nxt < 7) nxt++;
        end
        in_valid5 = 1'b0;
        chk("s2_windows", 192'(k), 192'(3));
        chk("s2_max_count_le5", 192'(maxc <= 5), 192'(1));
        chk("s2_final_count", 192'(count5), 192'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
